// File: rtl/fp_pkg.sv
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants and state encoding for the single-precision
//                FP adder datapath (aligner, normaliser, top).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int FRAC_W   = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_normalizer.sv
// ============================================================================
//  Module      : fp_normalizer
//  Description : Post-ALU normalisation stage. Shifts the raw significand one
//                bit per cycle until the hidden bit lands on FRAC_W, then packs
//                a binary32 word (truncating) and hands it downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_normalizer #(
    parameter int IN_W   = 32,
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [IN_W-1:0]         in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_zero,
    output logic                    out_ovf,
    output logic                    out_inexact
);

    import fp_pkg::*;

    // Internal exponent carries one extra bit so an increment past the
    // all-ones code is still observable before it is clamped to infinity.
    localparam logic [EXP_W:0] c_exp_max = (EXP_W+1)'(EXP_MAX);
    localparam logic [EXP_W:0] c_exp_one = (EXP_W+1)'(1);

    state_t                 r_state;
    logic                   r_sign;
    logic [EXP_W:0]         r_exp;
    logic [IN_W-1:0]        r_mant;
    logic                   r_sticky;

    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [EXP_W+FRAC_W:0]  r_result;
    logic                   r_zero;
    logic                   r_ovf;
    logic                   r_inexact;

    logic                   w_upper;
    logic [EXP_W:0]         w_exp_inc;
    logic                   w_exp_sat;

    // Decode the normalisation condition for the current iteration.
    always_comb begin
        w_upper   = |r_mant[IN_W-1:FRAC_W+1];
        w_exp_inc = r_exp + 1'b1;
        w_exp_sat = (w_exp_inc >= c_exp_max);
    end

    // Control FSM and iterative shifter; all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_sticky    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sign     <= in_sign;
                        // A zero exponent field means the denormal scale, which is 2^(1-bias).
                        r_exp      <= (in_exp == '0) ? c_exp_one : {1'b0, in_exp};
                        r_mant     <= in_mant;
                        r_sticky   <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_zero     <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_inexact  <= 1'b0;
                        r_state    <= NORM;
                    end
                end

                NORM: begin
                    if (r_mant == '0) begin
                        r_result  <= {r_sign, {(EXP_W+FRAC_W){1'b0}}};
                        r_zero    <= 1'b1;
                        r_inexact <= r_sticky;
                        r_state   <= DONE;
                    end else if (w_upper) begin
                        r_mant   <= r_mant >> 1;
                        r_exp    <= w_exp_inc;
                        r_sticky <= r_sticky | r_mant[0];
                        if (w_exp_sat) begin
                            r_result  <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                            r_ovf     <= 1'b1;
                            r_inexact <= r_sticky | r_mant[0];
                            r_state   <= DONE;
                        end
                    end else if (r_mant[FRAC_W]) begin
                        r_result  <= {r_sign, r_exp[EXP_W-1:0], r_mant[FRAC_W-1:0]};
                        r_inexact <= r_sticky;
                        r_state   <= DONE;
                    end else if (r_exp > c_exp_one) begin
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - 1'b1;
                    end else begin
                        // Exponent floor reached without a hidden bit: emit a denormal.
                        r_result  <= {r_sign, {EXP_W{1'b0}}, r_mant[FRAC_W-1:0]};
                        r_inexact <= r_sticky;
                        r_state   <= DONE;
                    end
                end

                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    assign out_zero    = r_zero;
    assign out_ovf     = r_ovf;
    assign out_inexact = r_inexact;

endmodule

`default_nettype wire

// File: tb/tb_fp_normalizer.sv
// ============================================================================
//  Module      : tb_fp_normalizer
//  Description : Scoreboard bench for fp_normalizer with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [31:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_inexact;

    fp_normalizer #(.IN_W(32), .EXP_W(8), .FRAC_W(23)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_mant     (in_mant),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_ovf     (out_ovf),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        ix;
        int          lat;   // cycles from accept edge to out_valid; -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   seen  = 1'b0;

    // Cycle counter and accept-edge log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready)
            acc_q.push_back(cyc + 1);
    end

    // Monitor: pops expectations as results are presented.
    int   m_acc;
    exp_t m_e;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL stale_output: out_valid=1 result=%h but no result expected", out_result);
            end else begin
                if (!seen) begin
                    seen  = 1'b1;
                    m_acc = (acc_q.size() > 0) ? acc_q.pop_front() : -100000;
                    if (exp_q[0].lat >= 0) begin
                        n_vec++;
                        if (cyc - m_acc != exp_q[0].lat) begin
                            n_bad++;
                            $display("FAIL latency: got %0d cycles, want %0d", cyc - m_acc, exp_q[0].lat);
                        end
                    end
                end
                if (!out_ready) begin
                    n_vec++;
                    if (out_result !== exp_q[0].res || in_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL hold: result=%h in_ready=%b, want result=%h in_ready=0",
                                 out_result, in_ready, exp_q[0].res);
                    end
                end else begin
                    m_e = exp_q.pop_front();
                    seen = 1'b0;
                    n_vec++;
                    if (out_result !== m_e.res || out_zero !== m_e.z ||
                        out_ovf !== m_e.o || out_inexact !== m_e.ix) begin
                        n_bad++;
                        $display("FAIL result: got %h z=%b ovf=%b ix=%b, want %h z=%b ovf=%b ix=%b",
                                 out_result, out_zero, out_ovf, out_inexact,
                                 m_e.res, m_e.z, m_e.o, m_e.ix);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Present one operand and hold it until accepted (bounded wait).
    task automatic drive(input logic s, input logic [7:0] e, input logic [31:0] m);
        int guard = 0;
        while (!in_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, want 1", in_ready, guard);
        end else begin
            in_sign  = s;
            in_exp   = e;
            in_mant  = m;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [31:0] m,
                        input logic [31:0] r, input logic z, input logic o,
                        input logic ix, input int lat);
        exp_t x;
        x.res = r; x.z = z; x.o = o; x.ix = ix; x.lat = lat;
        exp_q.push_back(x);
        drive(s, e, m);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result",    out_result,         32'h0);
        chk("reset_flags",     {29'b0, out_zero, out_ovf, out_inexact}, 32'd0);
        rst = 1'b0;

        //   sign  exp    mant           result        z     o     ix    lat
        send(1'b0, 8'd127, 32'h0080_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 2);
        send(1'b0, 8'd127, 32'h0100_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 3);
        send(1'b0, 8'd150, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 25);
        send(1'b1, 8'd100, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2);
        send(1'b0, 8'd2,   32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 3);
        send(1'b1, 8'd254, 32'h01FF_FFFF, 32'hFF80_0000, 1'b0, 1'b1, 1'b1, -1);
        send(1'b0, 8'd127, 32'h0180_0001, 32'h4040_0000, 1'b0, 1'b0, 1'b1, 3);
        send(1'b0, 8'd100, 32'h8000_0000, 32'h3600_0000, 1'b0, 1'b0, 1'b0, 10);
        send(1'b0, 8'd0,   32'h0040_0000, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 2);
        send(1'b0, 8'd0,   32'h0080_0000, 32'h0080_0000, 1'b0, 1'b0, 1'b0, 2);
        send(1'b0, 8'd5,   32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 6);
        send(1'b0, 8'd253, 32'h0400_0000, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, -1);
        drain();

        // Backpressure: result and flags must hold while out_ready is low.
        out_ready = 1'b0;
        send(1'b0, 8'd127, 32'h0100_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 3);
        begin
            int guard = 0;
            while (!out_valid && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a long left-shift sequence.
        drive(1'b0, 8'd150, 32'h0000_0001);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        acc_q.delete();
        seen = 1'b0;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("abort_no_stale", {31'b0, out_valid}, 32'd0);
        send(1'b1, 8'd130, 32'h0080_0000, 32'hC100_0000, 1'b0, 1'b0, 1'b0, 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
